muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even and at least 8.
REQ-002 Parameter SIGNED_EN, default 1; when 1, signed ops are supported; when 0, signed ops execute as unsigned.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request strobe, sampled at the rising edge.
REQ-006 op  input  3  MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 110 and 111 are reserved.
REQ-007 a, b  input  WIDTH  operands: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-008 flush  input  1  pipeline flush; cancels the op in flight.
REQ-009 busy  output  1  high while an iterative op is in flight.
REQ-010 done  output  1  one-cycle pulse when HI/LO is updated.
REQ-011 dz  output  1  sticky divide-by-zero flag of the last completed divide.
REQ-012 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIX, encoded in muldiv_pkg.
REQ-014 In IDLE, start with op MULT, MULTU, DIV or DIVU SHALL latch the operands and op, enter RUN, set busy at the same edge, and clear the iteration counter.
REQ-015 In IDLE, start with MTHI or MTLO SHALL write a to hi or lo respectively at that edge, stay in IDLE, and pulse done in the following cycle.
REQ-016 start with a reserved op, or start while busy, SHALL be ignored with no state change.
REQ-017 Signed ops SHALL convert both operands to magnitudes before entering RUN.
REQ-018 Multiply SHALL be radix-2 shift-add, one bit per cycle, WIDTH cycles in RUN, into a 2*WIDTH-bit accumulator.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle, WIDTH cycles in RUN.
REQ-020 FIX SHALL take one cycle and apply sign correction: the product is negated when the operand signs differ; the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
REQ-021 On leaving FIX, at the edge returning to IDLE, hi and lo SHALL be written, busy SHALL be cleared, and done SHALL be high for exactly the next cycle.
REQ-022 Total latency SHALL be WIDTH+1 cycles from the start edge to the result-write edge.
REQ-023 Multiply results SHALL be: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-024 Divide results SHALL be: lo = quotient, hi = remainder.
REQ-025 Divide by zero (b == 0) SHALL skip RUN and go straight to FIX, write hi = 0 and lo = 0, set dz, and pulse done after 1 cycle.
REQ-026 dz SHALL clear on the completion of any divide with b != 0 and SHALL be unaffected by multiply or MTHI/MTLO.
REQ-027 Signed overflow, most-negative / -1, SHALL yield lo = most-negative and hi = 0, with no flag.
REQ-028 flush while busy SHALL return the FSM to IDLE at the next edge, leave hi, lo and dz unchanged, and produce no done.
REQ-029 flush and start in the same cycle while IDLE: start SHALL be accepted.
REQ-030 flush in the FIX cycle SHALL cancel the write.
REQ-031 hi and lo SHALL be stable and readable while busy.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0, and the accumulators to 0.
REQ-033 Reset asserted mid-operation SHALL discard the op; after release, the first start SHALL behave as from power-up.

Structure
REQ-034 muldiv_pkg SHALL hold the op encodings, the state enum, and a function giving the counter width from WIDTH.
REQ-035 One sub-module, muldiv_signfix, SHALL be parametrised by WIDTH and SHALL perform both the magnitude conversion and the FIX-stage negation combinationally.
REQ-036 The datapath SHALL share one 2*WIDTH accumulator and one WIDTH+1 adder/subtractor between multiply and divide.

Verification
REQ-037 With WIDTH=32: MULT a=0xFFFFFFFF, b=2 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, with one done pulse; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0; DIV b=0 -> done after 1 cycle, hi=lo=0, dz=1; a following DIVU 4/2 -> dz=0.
REQ-040 MULT started, then a second start at cycle 5 and flush at cycle 10 -> second start ignored, no done, hi/lo hold the prior values, and a new op is accepted the next cycle.
REQ-041 MTHI a=0x12345678 -> hi updated at the start edge and done the following cycle; rst_n pulsed low mid-DIV -> all outputs 0 immediately, then a clean op after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states,
// and the iteration-counter width helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Counter only needs to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on entry to RUN and the
// negation of product / quotient / remainder in the FIX cycle.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               sgn_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    output logic               a_neg_o,
    output logic               b_neg_o,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               is_div_i,
    input  logic               neg_res_i,
    input  logic               neg_rem_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        a_neg_o = sgn_i & a_i[WIDTH-1];
        b_neg_o = sgn_i & b_i[WIDTH-1];
        a_mag_o = a_neg_o ? -a_i : a_i;
        b_mag_o = b_neg_o ? -b_i : b_i;

        prod = neg_res_i ? -acc_i : acc_i;
        quo  = acc_i[WIDTH-1:0];
        rem  = acc_i[2*WIDTH-1:WIDTH];

        // Divide keeps the remainder in the upper half, quotient in the lower.
        if (is_div_i) begin
            hi_o = neg_rem_i ? -rem : rem;
            lo_o = neg_res_i ? -quo : quo;
        end else begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply
// and restoring divide sharing one accumulator and one WIDTH+1 adder.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_op_q, dz_op_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic               op_mul, op_div, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     add_x, add_y;
    logic [WIDTH+1:0]   add_sum;

    assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign sgn    = (SIGNED_EN != 0) && ((op == OP_MULT) || (op == OP_DIV));

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .sgn_i     (sgn),
        .a_i       (a),
        .b_i       (b),
        .a_mag_o   (a_mag),
        .b_mag_o   (b_mag),
        .a_neg_o   (a_neg),
        .b_neg_o   (b_neg),
        .acc_i     (acc_q),
        .is_div_i  (is_div_q),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .hi_o      (fix_hi),
        .lo_o      (fix_lo)
    );

    // Shared adder: add multiplicand to the upper half, or trial-subtract the
    // divisor from the left-shifted partial remainder (carry out = no borrow).
    always_comb begin
        add_x   = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_y   = is_div_q ? ~{1'b0, m_q} : {1'b0, m_q};
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_op_d   = dz_op_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (op_mul || op_div)) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_op_d   = 1'b0;
                    if (op_mul) begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        m_d   = a_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        m_d   = b_mag;
                        if (b == '0) begin
                            state_d = ST_FIX;
                            dz_op_d = 1'b1;
                        end
                    end
                end else if (start && (op == OP_MTHI)) begin
                    hi_d   = a;
                    done_d = 1'b1;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d   = a;
                    done_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (add_sum[WIDTH+1]) begin
                            acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (acc_q[0]) begin
                            acc_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
                        end else begin
                            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (dz_op_q) begin
                        hi_d = '0;
                        lo_d = '0;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = fix_hi;
                        lo_d = fix_lo;
                        if (is_div_q) begin
                            dz_d = 1'b0;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_op_q   <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_op_q   <= dz_op_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference of HI/LO/dz and latency.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          flush;
    logic          busy, done, dz;
    logic [W-1:0]  hi, lo;

    logic [W-1:0]  hi_m, lo_m;
    logic          dz_m;
    int            n_chk;
    int            n_fail;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; latency in edges after the start edge
    // until done is seen (-1 means the request must be ignored).
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic fl);
        logic [W-1:0] old_hi, old_lo;
        longint       sx, sy, q, r;
        logic [63:0]  p;
        int           lat, n;
        old_hi = hi_m;
        old_lo = lo_m;
        sx = $signed(x);
        sy = $signed(y);
        lat = W + 1;
        case (o)
            3'b000: begin p = sx * sy; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'b001: begin p = {32'b0, x} * {32'b0, y}; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'b010, 3'b011: begin
                if (y == 0) begin
                    hi_m = 0; lo_m = 0; dz_m = 1'b1; lat = 1;
                end else begin
                    if (o == 3'b010) begin
                        q = sx / sy; r = sx % sy;
                        lo_m = q[31:0]; hi_m = r[31:0];
                    end else begin
                        lo_m = x / y; hi_m = x % y;
                    end
                    dz_m = 1'b0;
                end
            end
            3'b100: begin hi_m = x; lat = 0; end
            3'b101: begin lo_m = x; lat = 0; end
            default: lat = -1;
        endcase

        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;

        if (lat == 0) begin
            chk("mt_done", done, 1);
        end else if (lat > 0) begin
            chk("busy_set", busy, 1);
            chk("hi_stable", hi, old_hi);
            chk("lo_stable", lo, old_lo);
            n = 0;
            while (!done && n < 80) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", n, lat);
            chk("busy_clr", busy, 0);
        end else begin
            repeat (3) begin @(posedge clk); #1; end
            chk("rsv_done", done, 0);
            chk("rsv_busy", busy, 0);
        end
        chk("hi", hi, hi_m);
        chk("lo", lo, lo_m);
        chk("dz", dz, dz_m);
        if (lat >= 0) begin
            @(posedge clk); #1;
            chk("done_pulse", done, 0);
        end
        $display("op=%0d a=%h b=%h flush=%b -> hi=%h lo=%h dz=%b", o, x, y, fl, hi, lo, dz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b0; a = '0; b = '0;
        hi_m = '0; lo_m = '0; dz_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed corner cases
        run_op(3'b000, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("mult_hi_k", hi, 32'hFFFFFFFF);
        chk("mult_lo_k", lo, 32'hFFFFFFFE);
        run_op(3'b001, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("multu_hi_k", hi, 32'h00000001);
        run_op(3'b010, -32'sd7, 32'd2, 1'b0);
        chk("div_lo_k", lo, 32'hFFFFFFFD);
        chk("div_hi_k", hi, 32'hFFFFFFFF);
        run_op(3'b011, 32'd7, 32'd2, 1'b0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo_k", lo, 32'h80000000);
        run_op(3'b010, 32'd9, 32'd0, 1'b0);
        chk("dz_k", dz, 1);
        run_op(3'b000, 32'd3, 32'd5, 1'b0);          // multiply leaves dz alone
        run_op(3'b011, 32'd4, 32'd2, 1'b0);
        chk("dz_clr_k", dz, 0);
        run_op(3'b100, 32'h12345678, 32'd0, 1'b0);
        run_op(3'b101, 32'hCAFEF00D, 32'd0, 1'b0);
        run_op(3'b110, 32'h1111, 32'h2222, 1'b0);
        run_op(3'b111, 32'h3333, 32'h4444, 1'b0);
        run_op(3'b000, -32'sd3, -32'sd4, 1'b1);       // flush with start while idle

        // Flush mid-run with an ignored second start at cycle 5
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'h1234; b = 32'h5678;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
        @(posedge clk); #1; start = 1'b0;
        chk("ign_hi", hi, hi_m);
        chk("ign_busy", busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_hi", hi, hi_m);
        chk("flush_lo", lo, lo_m);
        $display("flush mid-run: hi=%h lo=%h busy=%b", hi, lo, busy);
        run_op(3'b001, 32'd100, 32'd200, 1'b0);

        // Flush during the FIX cycle cancels the write
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (W) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("fixflush_done", done, 0);
        chk("fixflush_busy", busy, 0);
        chk("fixflush_hi", hi, hi_m);
        chk("fixflush_lo", lo, lo_m);
        $display("flush in fix: hi=%h lo=%h done=%b", hi, lo, done);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset mid-divide
        run_op(3'b010, 32'd5, 32'd0, 1'b0);
        run_op(3'b100, 32'h12345678, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd12345; b = 32'd11;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dz", dz, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        $display("reset mid-div: hi=%h lo=%h dz=%b busy=%b", hi, lo, dz, busy);
        hi_m = '0; lo_m = '0; dz_m = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_op(3'b011, 32'd4, 32'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
